if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction prefetch queue for the IF stage: issues aligned fetches to instruction
//  memory, buffers returned data as 16-bit halfwords, realigns mixed RV32C/RV32I streams and presents
//  one decoded-length instruction per cycle to ID. Generalises the fixed-width IF FIFO with
//  configurable fetch width, depth and outstanding-request count, plus in-flight flush on redirect.
// PARAMETERS
//  DEPTH      8             queue capacity in halfwords; power of 2, >= 2*FETCH_W/16
//  FETCH_W    32            fetch data width in bits; 32 or 64 (HPF = FETCH_W/16 halfwords per fetch)
//  MAX_OUTST  2             max fetch requests in flight, 1..4
//  ADDR_W     32            address width
//  RESET_PC   32'h0000_0000 first fetch PC after reset; halfword aligned
// PORTS
//  clk             in   1        core clock
//  reset           in   1        asynchronous, active-high reset
//  imem_req_valid  out  1        fetch request valid
//  imem_req_addr   out  ADDR_W   fetch address, aligned to FETCH_W/8 bytes
//  imem_req_ready  in   1        memory accepts request
//  imem_rsp_valid  in   1        fetch data valid; responses return in request order
//  imem_rsp_data   in   FETCH_W  fetch data, lowest halfword = lowest address
//  redirect_i      in   1        flush + restart (branch/jump/trap)
//  redirect_pc_i   in   ADDR_W   new PC, halfword aligned
//  instr_valid_o   out  1        instr_o/instr_pc_o valid
//  instr_o         out  32       instruction; compressed -> {16'b0, hw}
//  instr_pc_o      out  ADDR_W   PC of instr_o
//  is_compress_o   out  1        instr_o is 16-bit
//  instr_ready_i   in   1        ID consumes instruction (pop)
//  level_o         out  $clog2(DEPTH)+1  halfwords held
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-fetch): queue empty, level_o=0, instr_valid_o=0, is_compress_o=0,
//    instr_o=0, instr_pc_o=RESET_PC, imem_req_valid=0, outstanding=0, stale=0, skip=RESET_PC[1+:log2(HPF)].
//    First cycle after reset deasserts: imem_req_valid=1, addr=RESET_PC aligned down.
//  - Request: valid when outstanding<MAX_OUTST and DEPTH-level >= HPF*(outstanding+1); addr held stable
//    until ready. Handshake: outstanding++ and fetch addr += FETCH_W/8.
//  - Response: if stale>0 -> discard, stale--; else write HPF halfwords, first `skip` of them dropped
//    (skip cleared after first kept response); outstanding-- either way. Ptrs wrap modulo DEPTH.
//  - Output (combinational from head): head hw[1:0]!=2'b11 -> compressed, valid if level>=1;
//    else 32-bit {hw1,hw0}, valid only if level>=2 (spanning fetch boundary waits for next response).
//  - Pop on instr_valid_o & instr_ready_i: remove 1 or 2 halfwords, instr_pc_o += 2 or 4.
//  - Same-cycle write+pop legal; level = level + kept - popped, never exceeds DEPTH.
//  - Redirect (registered, effective next cycle): queue cleared, instr_valid_o=0, instr_pc_o=redirect_pc_i,
//    fetch addr=redirect_pc_i aligned down, skip=redirect_pc_i[1+:log2(HPF)],
//    stale = outstanding + (req handshake this cycle) - (rsp this cycle). Pop, write and response in
//    the redirect cycle are ignored/discarded. A pending unaccepted request is replaced (only exception to
//    address stability). Back-to-back redirects: last wins; stale accumulates correctly.
//  - Fetch address wraps modulo 2^ADDR_W silently.
//  - Consumer-side FSM: EMPTY (level 0) / PARTIAL (only hw0 of 32-bit instr) / READY (valid) — derived,
//    not a separate state register.
// TESTING (DEPTH=8, FETCH_W=32, MAX_OUTST=2, RESET_PC=0, memory 1-cycle latency, ready=1 unless noted)
//  1 Reset release, word@0x0=0x00A00093 -> instr_o=0x00A00093, pc=0x0, is_compress_o=0, next req 0x4.
//  2 word@0x4=0x45054501 -> two pops: 0x00004501 pc 0x4, then 0x00004505 pc 0x6, both is_compress_o=1.
//  3 word@0x8=0x00934501, word@0xC=0x000000A0 -> 0x00004501 pc 0x8; 0x00A00093 pc 0xA valid only
//    after 0xC response arrives.
//  4 Redirect to 0x102 with 2 requests outstanding -> both responses dropped, next req 0x100, first
//    instr pc 0x102 from upper halfword of word@0x100.
//  5 instr_ready_i=0 for 20 cycles -> level_o saturates at 8, imem_req_valid=0, no data loss;
//    release -> in-order PCs 0x0,0x4,... resume fetching.
//  6 Assert reset with 1 request in flight and level=4 -> all outputs at reset values; late response
//    ignored; refetch starts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: IF-stage prefetch queue that buffers fetched halfwords and realigns mixed RV32C/RV32I streams for ID.
module if_prefetch_queue #(
    parameter int                DEPTH     = 8,
    parameter int                FETCH_W   = 32,
    parameter int                MAX_OUTST = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [FETCH_W-1:0]       imem_rsp_data,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [ADDR_W-1:0]        instr_pc_o,
    output logic                     is_compress_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int HPF = FETCH_W / 16;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int SW  = $clog2(HPF);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(FETCH_W / 8 - 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, READY} cstate_t;

    logic [15:0]       r_q [DEPTH];
    logic [PW-1:0]     r_rd, r_wr;
    logic [LW-1:0]     r_level;
    logic [OW-1:0]     r_outst, r_stale;
    logic [SW-1:0]     r_skip;
    logic [ADDR_W-1:0] r_addr, r_pc;

    logic [15:0]       w_hw0, w_hw1;
    logic              w_comp, w_valid, w_req, w_hs, w_rsp, w_keep, w_pop;
    logic [LW-1:0]     w_kept, w_popped;
    logic [OW-1:0]     w_outst_nxt;
    cstate_t           w_state;

    assign w_hw0  = r_q[r_rd];
    assign w_hw1  = r_q[r_rd + PW'(1)];
    assign w_comp = w_hw0[1:0] != 2'b11;

    // PARTIAL: only the low half of a 32-bit instruction has arrived
    always_comb w_state = (r_level == '0) ? EMPTY :
                          (!w_comp && r_level == LW'(1)) ? PARTIAL : READY;

    assign w_valid  = w_state == READY;
    assign w_req    = !reset && (int'(r_outst) < MAX_OUTST) &&
                      (DEPTH - int'(r_level) >= HPF * (int'(r_outst) + 1));
    assign w_hs     = w_req && imem_req_ready;
    // a response with nothing outstanding (e.g. one issued before reset) is dropped
    assign w_rsp    = imem_rsp_valid && r_outst != '0;
    assign w_keep   = w_rsp && !redirect_i && r_stale == '0;
    assign w_pop    = w_valid && instr_ready_i && !redirect_i;
    assign w_kept   = w_keep ? LW'(HPF) - LW'(r_skip) : '0;
    assign w_popped = w_pop ? (w_comp ? LW'(1) : LW'(2)) : '0;
    assign w_outst_nxt = r_outst + OW'(w_hs) - OW'(w_rsp);

    assign imem_req_valid = w_req;
    assign imem_req_addr  = r_addr;
    assign instr_valid_o  = w_valid;
    assign instr_o        = w_valid ? (w_comp ? {16'h0000, w_hw0} : {w_hw1, w_hw0}) : '0;
    assign is_compress_o  = w_valid && w_comp;
    assign instr_pc_o     = r_pc;
    assign level_o        = r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_outst <= '0;
            r_stale <= '0;
            r_skip  <= RESET_PC[1 +: SW];
            r_addr  <= RESET_PC & ALIGN;
            r_pc    <= RESET_PC;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_i) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_level <= '0;
                r_stale <= w_outst_nxt;
                r_skip  <= redirect_pc_i[1 +: SW];
                r_addr  <= redirect_pc_i & ALIGN;
                r_pc    <= redirect_pc_i;
            end else begin
                r_level <= r_level + w_kept - w_popped;
                r_rd    <= r_rd + PW'(w_popped);
                r_wr    <= r_wr + PW'(w_kept);
                if (w_rsp && r_stale != '0) r_stale <= r_stale - OW'(1);
                if (w_keep) r_skip <= '0;
                if (w_hs) r_addr <= r_addr + ADDR_W'(FETCH_W / 8);
                if (w_pop) r_pc <= r_pc + (w_comp ? ADDR_W'(2) : ADDR_W'(4));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_keep)
            for (int i = 0; i < HPF; i++)
                if (i >= int'(r_skip))
                    r_q[r_wr + PW'(i) - PW'(r_skip)] <= imem_rsp_data[16*i +: 16];
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed bench with an in-order 1-cycle memory model and an ID consumer log.
module tb_if_prefetch_queue;
    logic        clk = 0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        is_compress_o;
    logic        instr_ready_i;
    logic [3:0]  level_o;

    logic        hold;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] con_i[$];
    logic [31:0] con_pc[$];
    logic        con_c[$];

    if_prefetch_queue #(.DEPTH(8), .FETCH_W(32), .MAX_OUTST(2), .ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .is_compress_o(is_compress_o), .instr_ready_i(instr_ready_i), .level_o(level_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A00093;
            32'h4:   return 32'h45054501;
            32'h8:   return 32'h00934501;
            32'hC:   return 32'h000000A0;
            32'h100: return 32'h45850001;
            default: return 32'h00010001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_con(input int n);
        int k = 0;
        while (con_pc.size() < n && k < 80) begin
            @(negedge clk);
            k++;
        end
        check("wait_con", 32'(con_pc.size() >= n), 32'd1);
    endtask

    task automatic clear_logs();
        req_log.delete();
        con_i.delete();
        con_pc.delete();
        con_c.delete();
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic ir);
        @(negedge clk);
        imem_req_ready = 0;
        instr_ready_i  = ir;
        redirect_i     = 1;
        redirect_pc_i  = pc;
        @(negedge clk);
        redirect_i = 0;
        repeat (3) @(negedge clk);
        clear_logs();
    endtask

    // memory: answers each accepted request on the following cycle unless held
    initial begin
        imem_rsp_valid = 0;
        imem_rsp_data  = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!hold && pend.size() > 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = mem_rd(pend.pop_front());
            end else imem_rsp_valid = 0;
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                req_log.push_back(imem_req_addr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (instr_valid_o && instr_ready_i && !redirect_i && !reset) begin
                con_i.push_back(instr_o);
                con_pc.push_back(instr_pc_o);
                con_c.push_back(is_compress_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc[8] = '{32'h0, 32'h4, 32'h6, 32'h8, 32'hA, 32'hE, 32'h10, 32'h12};
        logic [31:0] exp_in[8] = '{32'h00A00093, 32'h4501, 32'h4505, 32'h4501,
                                   32'h00A00093, 32'h0, 32'h1, 32'h1};
        reset = 1; redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0; imem_req_ready = 1; hold = 0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        check("rst_comp", 32'(is_compress_o), 32'd0);
        check("rst_req", 32'(imem_req_valid), 32'd0);

        // 32-bit then two compressed, then one spanning a word boundary
        @(negedge clk);
        reset = 0;
        instr_ready_i = 1;
        wait_con(5);
        check("t1_instr", con_i[0], 32'h00A00093);
        check("t1_pc", con_pc[0], 32'h0);
        check("t1_comp", 32'(con_c[0]), 32'd0);
        check("t1_req0", req_log[0], 32'h0);
        check("t1_req1", req_log[1], 32'h4);
        check("t2_instr0", con_i[1], 32'h4501);
        check("t2_pc0", con_pc[1], 32'h4);
        check("t2_comp0", 32'(con_c[1]), 32'd1);
        check("t2_instr1", con_i[2], 32'h4505);
        check("t2_pc1", con_pc[2], 32'h6);
        check("t2_comp1", 32'(con_c[2]), 32'd1);
        check("t3s_pc", con_pc[4], 32'hA);
        check("t3s_instr", con_i[4], 32'h00A00093);

        // upper half of 0x8 must wait for the 0xC response
        do_redirect(32'h8, 1);
        imem_req_ready = 1;
        @(negedge clk);
        imem_req_ready = 0;
        repeat (3) @(negedge clk);
        #2;
        check("t3_count", 32'(con_pc.size()), 32'd1);
        check("t3_instr0", con_i[0], 32'h4501);
        check("t3_pc0", con_pc[0], 32'h8);
        check("t3_partial_valid", 32'(instr_valid_o), 32'd0);
        check("t3_partial_level", 32'(level_o), 32'd1);
        @(negedge clk);
        imem_req_ready = 1;
        wait_con(2);
        check("t3_instr1", con_i[1], 32'h00A00093);
        check("t3_pc1", con_pc[1], 32'hA);
        check("t3_comp1", 32'(con_c[1]), 32'd0);

        // redirect with two requests in flight
        @(negedge clk);
        hold = 1;
        repeat (10) @(negedge clk);
        #2;
        check("t4_pending", 32'(pend.size()), 32'd2);
        check("t4_req_block", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_i = 1;
        redirect_pc_i = 32'h102;
        hold = 0;
        clear_logs();
        @(negedge clk);
        redirect_i = 0;
        wait_con(2);
        check("t4_req", req_log[0], 32'h100);
        check("t4_instr0", con_i[0], 32'h4585);
        check("t4_pc0", con_pc[0], 32'h102);
        check("t4_comp0", 32'(con_c[0]), 32'd1);
        check("t4_instr1", con_i[1], 32'h0001);
        check("t4_pc1", con_pc[1], 32'h104);

        // consumer stall: queue fills to DEPTH, fetching stops, nothing lost
        do_redirect(32'h0, 0);
        imem_req_ready = 1;
        repeat (20) @(negedge clk);
        #2;
        check("t5_level", 32'(level_o), 32'd8);
        check("t5_req_block", 32'(imem_req_valid), 32'd0);
        check("t5_req_count", 32'(req_log.size()), 32'd4);
        @(negedge clk);
        instr_ready_i = 1;
        wait_con(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_pc%0d", i), con_pc[i], exp_pc[i]);
            check($sformatf("t5_instr%0d", i), con_i[i], exp_in[i]);
        end
        check("t5_resume", req_log[4], 32'h10);

        // reset with one request in flight and four halfwords queued
        do_redirect(32'h0, 0);
        imem_req_ready = 1;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 0;
        @(negedge clk);
        hold = 1;
        imem_req_ready = 1;
        @(negedge clk);
        imem_req_ready = 0;
        #2;
        check("t6_pre_level", 32'(level_o), 32'd4);
        check("t6_pre_pending", 32'(pend.size()), 32'd1);
        @(negedge clk);
        reset = 1;
        clear_logs();
        #2;
        check("t6_level", 32'(level_o), 32'd0);
        check("t6_valid", 32'(instr_valid_o), 32'd0);
        check("t6_instr", instr_o, 32'd0);
        check("t6_pc", instr_pc_o, 32'd0);
        check("t6_comp", 32'(is_compress_o), 32'd0);
        check("t6_req", 32'(imem_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        hold = 0;
        imem_req_ready = 1;
        instr_ready_i = 1;
        @(negedge clk);
        #2;
        check("t6_late_ignored", 32'(level_o), 32'd0);
        wait_con(1);
        check("t6_req0", req_log[0], 32'h0);
        check("t6_instr0", con_i[0], 32'h00A00093);
        check("t6_pc0", con_pc[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
